// File: rtl/brancher_n_pkg.sv
// Shared helpers for the N-way stream brancher: width math and the
// lowest-set-bit selector used by unicast routing.
package brancher_n_pkg;

  localparam int MAX_CHANNELS = 16;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // A depth-1 FIFO still needs a 1-bit pointer to index its storage.
  function automatic int ptr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic logic [MAX_CHANNELS-1:0] lowest_one(input logic [MAX_CHANNELS-1:0] mask);
    return mask & (~mask + 16'd1);
  endfunction

endpackage

// File: rtl/brancher_fifo.sv
// Single-channel DEPTH-entry FIFO behind one brancher output; optional
// burst mode lets a full FIFO take a word in the cycle its head leaves.
module brancher_fifo
  import brancher_n_pkg::*;
#(
  parameter int    WIDTH = 32,
  parameter int    DEPTH = 2,
  parameter string BURST = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM,
  output logic             oReady_AM,
  input  logic [WIDTH-1:0] iData_AM,
  output logic             oValid_BM,
  input  logic             iReady_BM,
  output logic [WIDTH-1:0] oData_BM
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam bit BURST_EN = (BURST == "yes");

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  assign oValid_BM = (count != '0);
  assign oData_BM  = mem[rd_ptr];
  assign pop       = oValid_BM & iReady_BM;
  assign oReady_AM = iRST & ((count < FULL) | (BURST_EN & (count == FULL) & pop));
  assign push      = iValid_AM & oReady_AM;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= iData_AM;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/brancher_n.sv
// N-way stream brancher: routes one valid/ready stream to a unicast or
// multicast subset of per-channel FIFOs with all-or-nothing acceptance.
module brancher_n
  import brancher_n_pkg::*;
#(
  parameter int    CHANNELS  = 4,
  parameter int    WIDTH     = 32,
  parameter int    DEPTH     = 2,
  parameter string BURST     = "yes",
  parameter string MULTICAST = "no"
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iValid_AM,
  output logic                      oReady_AM,
  input  logic [CHANNELS-1:0]       iSelect_AM,
  input  logic [CHANNELS*WIDTH-1:0] iData_AM,
  output logic [CHANNELS-1:0]       oValid_BM,
  input  logic [CHANNELS-1:0]       iReady_BM,
  output logic [CHANNELS*WIDTH-1:0] oData_BM
);

  logic [CHANNELS-1:0] sel_eff, acc, push;

  assign sel_eff = (MULTICAST == "yes") ? iSelect_AM
                 : CHANNELS'(lowest_one(MAX_CHANNELS'(iSelect_AM)));

  // Unselected channels never block; an empty mask is consumed and dropped.
  assign oReady_AM = iRST & (&(acc | ~sel_eff));

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign push[k] = iValid_AM & oReady_AM & sel_eff[k];

      brancher_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .BURST(BURST)
      ) u_fifo (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iValid_AM(push[k]),
        .oReady_AM(acc[k]),
        .iData_AM (iData_AM[k*WIDTH +: WIDTH]),
        .oValid_BM(oValid_BM[k]),
        .iReady_BM(iReady_BM[k]),
        .oData_BM (oData_BM[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_brancher_n.sv
// Bench for brancher_n: three configurations checked every cycle against a
// queue-per-channel model, plus table vectors and directed corner sequences.
module tb_brancher_n;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int NI = 3;
  localparam int DEP [NI] = '{2, 2, 3};
  localparam int BUR [NI] = '{1, 0, 0};
  localparam int MC  [NI] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          v    [NI];
  logic          rdy  [NI];
  logic [CH-1:0] sel  [NI];
  logic [CH-1:0] ov   [NI];
  logic [CH-1:0] ir   [NI];
  logic [CH*W-1:0] din  [NI];
  logic [CH*W-1:0] dout [NI];

  brancher_n #(.CHANNELS(CH), .WIDTH(W), .DEPTH(2), .BURST("yes"), .MULTICAST("no")) u_a (
    .iCLK(clk), .iRST(rst_n), .iValid_AM(v[0]), .oReady_AM(rdy[0]), .iSelect_AM(sel[0]),
    .iData_AM(din[0]), .oValid_BM(ov[0]), .iReady_BM(ir[0]), .oData_BM(dout[0]));

  brancher_n #(.CHANNELS(CH), .WIDTH(W), .DEPTH(2), .BURST("no"), .MULTICAST("yes")) u_b (
    .iCLK(clk), .iRST(rst_n), .iValid_AM(v[1]), .oReady_AM(rdy[1]), .iSelect_AM(sel[1]),
    .iData_AM(din[1]), .oValid_BM(ov[1]), .iReady_BM(ir[1]), .oData_BM(dout[1]));

  brancher_n #(.CHANNELS(CH), .WIDTH(W), .DEPTH(3), .BURST("no"), .MULTICAST("no")) u_c (
    .iCLK(clk), .iRST(rst_n), .iValid_AM(v[2]), .oReady_AM(rdy[2]), .iSelect_AM(sel[2]),
    .iData_AM(din[2]), .oValid_BM(ov[2]), .iReady_BM(ir[2]), .oData_BM(dout[2]));

  int nchk = 0;
  int nerr = 0;
  logic [W-1:0] mq [NI*CH][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Destination set from the routing rule: whole mask, or only its lowest bit.
  function automatic logic [CH-1:0] eff(input int i, input logic [CH-1:0] s);
    if (MC[i] != 0) return s;
    for (int k = 0; k < CH; k++)
      if (s[k]) return CH'(1) << k;
    return '0;
  endfunction

  function automatic bit mdl_ready(input int i);
    logic [CH-1:0] e;
    int n;
    if (!rst_n) return 1'b0;
    e = eff(i, sel[i]);
    for (int k = 0; k < CH; k++) begin
      n = mq[i*CH+k].size();
      if (e[k] && !(n < DEP[i] || (BUR[i] != 0 && n == DEP[i] && ir[i][k]))) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Compare all outputs on the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit              er  [NI];
    logic [CH-1:0]   e   [NI];
    logic            vv  [NI];
    logic [CH-1:0]   irr [NI];
    logic [CH*W-1:0] dd  [NI];
    logic            rs;
    int              idx;
    @(negedge clk);
    rs = rst_n;
    for (int i = 0; i < NI; i++) begin
      er[i]  = mdl_ready(i);
      e[i]   = eff(i, sel[i]);
      vv[i]  = v[i];
      irr[i] = ir[i];
      dd[i]  = din[i];
      chk($sformatf("rdy%0d", i), 32'(rdy[i]), 32'(er[i]));
      for (int k = 0; k < CH; k++) begin
        idx = i*CH + k;
        chk($sformatf("vld%0d_%0d", i, k), 32'(ov[i][k]), 32'(mq[idx].size() != 0));
        if (mq[idx].size() != 0)
          chk($sformatf("dat%0d_%0d", i, k), 32'(dout[i][k*W +: W]), 32'(mq[idx][0]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < CH; k++) begin
        idx = i*CH + k;
        if (!rs) mq[idx].delete();
        else begin
          if (mq[idx].size() != 0 && irr[i][k]) void'(mq[idx].pop_front());
          if (vv[i] && er[i] && e[i][k]) mq[idx].push_back(dd[i][k*W +: W]);
        end
      end
    end
    #1;
  endtask

  typedef struct {
    logic [CH-1:0] sel;
    logic [CH-1:0] ov_uni;
    logic [CH-1:0] ov_mc;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, cyc;
    bit took;

    tbl[0] = '{4'b1010, 4'b0010, 4'b1010};
    tbl[1] = '{4'b0110, 4'b0010, 4'b0110};
    tbl[2] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[3] = '{4'b1000, 4'b1000, 4'b1000};
    tbl[4] = '{4'b1111, 4'b0001, 4'b1111};
    tbl[5] = '{4'b1100, 4'b0100, 4'b1100};

    // Reset held for several edges with a valid word pending.
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      v[i] = 1'b1; sel[i] = 4'b0101; ir[i] = '1; din[i] = $urandom;
    end
    @(posedge clk); #1;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk("rst_rdy", 32'(rdy[i]), 32'd0);
      chk("rst_ov", 32'(ov[i]), 32'd0);
      chk("rst_dout", dout[i], 32'd0);
      v[i] = 1'b0;
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk("post_rst_rdy", 32'(rdy[i]), 32'd1);
    step();

    // Unicast rotation, no back-pressure: each word visible the cycle after acceptance.
    for (int n = 0; n < 8; n++) begin
      v[0] = 1'b1; sel[0] = CH'(1) << (n % 4); din[0] = {4{8'hA0 + 8'(n)}};
      step();
      chk("uni_lat", 32'(ov[0]), 32'(CH'(1) << (n % 4)));
    end
    v[0] = 1'b0;
    repeat (2) step();

    // Routing table on the unicast and multicast instances.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 2; i++) begin
        v[i] = 1'b1; sel[i] = tbl[t].sel; din[i] = 32'h33221100;
      end
      step();
      chk("tbl_ov_uni", 32'(ov[0]), 32'(tbl[t].ov_uni));
      chk("tbl_ov_mc", 32'(ov[1]), 32'(tbl[t].ov_mc));
      v[0] = 1'b0; v[1] = 1'b0;
      step();
    end

    // Multicast all-or-nothing with channel 2 stalled and full.
    ir[1] = 4'b1011; v[1] = 1'b1; sel[1] = 4'b0100; din[1] = 32'h0A0B0C0D;
    repeat (2) step();
    sel[1] = 4'b0101; din[1] = 32'h00EE00EE;
    #1 chk("mc_blk_rdy", 32'(rdy[1]), 32'd0);
    step();
    chk("mc_no_write", 32'(ov[1][0]), 32'd0);
    ir[1] = '1;
    #1 chk("mc_noburst_rdy", 32'(rdy[1]), 32'd0);
    step();
    chk("mc_late_rdy", 32'(rdy[1]), 32'd1);
    step();
    chk("mc_both", 32'({ov[1][2], ov[1][0]}), 32'd3);
    v[1] = 1'b0;
    repeat (3) step();

    // Depth-3 wrap with random then steady back-pressure on channel 0.
    sel[2] = 4'b0001; acc_n = 0; cyc = 0;
    while (acc_n < 15 && cyc < 300) begin
      v[2] = 1'b1; din[2] = {4{8'h50 + 8'(acc_n)}};
      ir[2] = (acc_n < 10) ? {3'b111, 1'($urandom)} : 4'b1111;
      #1 took = rdy[2];
      step();
      if (took) acc_n++;
      cyc++;
    end
    chk("wrap_budget", 32'(acc_n), 32'd15);
    v[2] = 1'b0; ir[2] = '1;
    repeat (4) step();
    chk("wrap_drained", 32'(ov[2]), 32'd0);

    // Reset mid-stream discards buffered words.
    ir[2] = 4'b0000; v[2] = 1'b1;
    repeat (3) begin din[2] = $urandom; step(); end
    chk("mid_full", 32'(ov[2][0]), 32'd1);
    chk("mid_full_rdy", 32'(rdy[2]), 32'd0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_ov", 32'(ov[2]), 32'd0);
    rst_n = 1'b1; v[2] = 1'b0; ir[2] = '1;
    step();

    // Randomised traffic on all instances against the model.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NI; i++) begin
        v[i]   = 1'($urandom);
        sel[i] = CH'($urandom);
        din[i] = $urandom;
        ir[i]  = CH'($urandom | $urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/brancher_n.md
# brancher_n

Parametrised N-way stream brancher: one valid/ready input stream is routed to any subset of CHANNELS output streams, each buffered by its own DEPTH-entry FIFO. It generalises the two-way brancher in three ways: arbitrary channel count, selectable FIFO depth, and an optional multicast mode. It sits between a producer and several consumers in the datapath, wherever one result stream fans out to several processing lanes.

## Interface
- CHANNELS, 4: number of output channels, 2..16.
- WIDTH, 32: data width per channel slice.
- DEPTH, 2: entries per output FIFO, 1..16.
- BURST, "yes": "yes" lets a full FIFO accept a word in the same cycle its head is popped; "no" gives ready = not full.
- MULTICAST, "no": "yes" delivers to every selected channel; "no" delivers to the lowest selected channel only.
- iCLK  in  1  clock.
- iRST  in  1  synchronous reset, active-low.
- iValid_AM  in  1  input word valid.
- oReady_AM  out  1  input word accepted this cycle when high together with iValid_AM.
- iSelect_AM  in  CHANNELS  destination mask, bit k selects channel k.
- iData_AM  in  CHANNELS*WIDTH  concatenated slices; slice k, bits [k*WIDTH +: WIDTH], goes to channel k.
- oValid_BM  out  CHANNELS  per-channel output valid.
- iReady_BM  in  CHANNELS  per-channel downstream ready.
- oData_BM  out  CHANNELS*WIDTH  per-channel output data, slice k for channel k.

## Operation
- Effective mask:
  - MULTICAST="yes": E = iSelect_AM.
  - MULTICAST="no": E = lowest set bit of iSelect_AM, e.g. 4'b0110 gives 4'b0010.
- Channel k can accept (acc[k]):
  - BURST="no": count[k] < DEPTH.
  - BURST="yes": count[k] < DEPTH, or (count[k]==DEPTH and oValid_BM[k] and iReady_BM[k]).
- oReady_AM = &(acc | ~E). Acceptance is all-or-nothing: no selected channel is written unless every selected channel can accept.
- Push to channel k when iValid_AM & oReady_AM & E[k].
- E == 0 gives oReady_AM=1. The word is consumed and dropped, and no FIFO changes.
- Each FIFO is first-in first-out. oValid_BM[k] = (count[k] != 0). oData_BM slice k is the head entry.
- Pop on oValid_BM[k] & iReady_BM[k].
- Same-cycle push and pop on one channel leaves count unchanged. Pointers wrap modulo DEPTH.
- oValid_BM[k] does not depend on iReady_BM[k].
- oData_BM slice k is held stable while oValid_BM[k] is high and the word is not popped.
- Channels are independent. A stalled channel blocks only inputs that select it.

## Timing
- Reset (iRST low at a clock edge):
  - all counts and pointers go to 0;
  - oValid_BM = 0 and oData_BM = 0 (storage cleared);
  - oReady_AM is forced 0 while iRST is low.
- Reset mid-transfer discards all buffered words. No push or pop occurs on a reset edge.
- Latency: a word accepted at edge t is visible on oValid_BM/oData_BM after edge t, i.e. in cycle t+1. There is no combinational input-to-output data path.
- Throughput: one word per cycle per channel if DEPTH≥2, or if BURST="yes" with DEPTH=1. With BURST="no" and DEPTH=1 the maximum is one word every 2 cycles.
- Combinational paths:
  - oReady_AM depends on iSelect_AM always.
  - oReady_AM depends on iReady_BM only when BURST="yes".
  - oReady_AM never depends on iValid_AM.

## Structure
- The shared package holds:
  - function lowest_one(mask);
  - clog2 helper for pointer and count widths: pointer width clog2(DEPTH) with a minimum of 1, count width clog2(DEPTH+1).
- One sub-module, brancher_fifo (WIDTH, DEPTH, BURST), is instantiated CHANNELS times via generate. It has:
  - ports iValid_AM, oReady_AM, iData_AM, oValid_BM, iReady_BM, oData_BM, iRST, iCLK;
  - the same reset and BURST rules as above.
- The top level contains only the mask and ready logic.

## Test plan
- Reset: drive iRST=0 for 3 cycles with iValid_AM=1 -> oReady_AM=0, oValid_BM=0, oData_BM=0. After release oReady_AM=1 with any nonzero select.
- Unicast ordering (CHANNELS=4, DEPTH=2): send 0xA0..0xA7 with select rotating 1,2,4,8, all iReady_BM=1 -> each channel outputs its two words in order, 1 cycle after acceptance, with no stalls.
- Lowest-bit rule (MULTICAST="no"): select 4'b1010, slice1=0x11, slice3=0x33 -> only channel 1 outputs 0x11; channel 3 stays invalid.
- Multicast all-or-nothing (MULTICAST="yes", DEPTH=2):
  - hold iReady_BM[2]=0 and fill channel 2 with 2 words;
  - send select 4'b0101 -> oReady_AM=0 and channel 0 is not written;
  - raise iReady_BM[2] -> the word is accepted on both channels in the same cycle (BURST="yes") or one cycle later (BURST="no").
- Empty mask: select 0 with valid -> accepted in 1 cycle; all counts unchanged; oValid_BM stays 0.
- Wrap and simultaneous push/pop (DEPTH=3, channel 0):
  - stream 10 words with iReady_BM[0] toggled randomly;
  - stream a further 5 words with iReady_BM[0] held at 1;
  - required: output order matches input, no loss or duplication, count never exceeds 3, and reset asserted mid-stream empties the FIFO on the next edge.
